// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RISC-V pipeline: forwarding, load-use, branch flush,
// multi-cycle E-stage sequencing and data-memory wait stalls. Define HAZARD_PERF_EN for perf counters.

module hazard_fwd_sel #(
    parameter int REG_W = 5
) (
    input  logic             we_m,
    input  logic             we_w,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic [REG_W-1:0] rs,
    output logic [1:0]       fwd
);
    // The M-stage result is younger, so it shadows the W-stage one.
    always_comb begin
        fwd = 2'b00;
        if (we_m && (rd_m != '0) && (rd_m == rs))
            fwd = 2'b10;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            fwd = 2'b01;
    end
endmodule

module hazard_unit_mc #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic             PCSrcE,
    input  logic             ResultSrcE0,
    input  logic             MulStartE,
    input  logic             MemBusyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MulBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      StallCycles,
    output logic [31:0]      FlushEvents
`endif
);
    localparam int NUM_OPS = 2;

    logic [NUM_OPS-1:0][REG_W-1:0] rs_e;
    logic [NUM_OPS-1:0][1:0]       fwd;
    logic                          mem_stall;
    logic                          lw_stall;
    logic                          mul_stall;
    logic                          mul_busy;

    assign rs_e = {Rs2E, Rs1E};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        hazard_fwd_sel #(.REG_W(REG_W)) u_fwd (
            .we_m (RegWriteM),
            .we_w (RegWriteW),
            .rd_m (RdM),
            .rd_w (RdW),
            .rs   (rs_e[g]),
            .fwd  (fwd[g])
        );
    end

    assign mem_stall = MemBusyM;
    assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

    if (MUL_LAT >= 2) begin : g_fsm
        typedef enum logic {IDLE, BUSY} state_t;

        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // cnt counts the E cycles still owed; the last one (cnt==1) lets E advance.
        // A memory wait freezes the whole sequence, including the start.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            mul_stall = 1'b0;
            case (state_q)
                IDLE: begin
                    if (MulStartE && !mem_stall) begin
                        mul_stall = 1'b1;
                        state_d   = BUSY;
                        cnt_d     = CNT_W'(MUL_LAT - 1);
                    end
                end
                BUSY: begin
                    mul_stall = (cnt_q > CNT_W'(1));
                    if (!mem_stall) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1))
                            state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign mul_busy = mul_stall || (state_q == BUSY);
    end else begin : g_nofsm
        assign mul_stall = 1'b0;
        assign mul_busy  = 1'b0;
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        MulBusy   = 1'b0;
        if (rst) begin
            ForwardAE = fwd[0];
            ForwardBE = fwd[1];
            MulBusy   = mul_busy;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (mul_stall) begin
                // A branch in E cannot resolve while E is held, so PCSrcE is ignored.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                FlushD = PCSrcE;
            end else begin
                FlushD = PCSrcE;
                FlushE = PCSrcE;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // FlushD is only ever raised by a taken branch, so it marks a branch flush.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, StallF};
        flush_events_d = flush_events_q + {31'd0, FlushD};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushEvents = flush_events_q;
`endif
endmodule
